half_frame_tx_streamer: RTL and testbench

Downstream stage of `image_half`. It captures one complete downsized frame (NEW_WIDTH×NEW_HEIGHT pixels, addressed writes) into an internal buffer. It then streams the frame byte-by-byte, in raster order and prefixed by a sync byte, to `uart_tx` over its start/done handshake. This replaces the direct `resize_out` → `data_i` latch in the top level, which loses pixels whenever the downsizer outpaces the UART.

---
 rtl/sift_pkg.sv | 16 +
 rtl/xilinx_single_port_ram_read_first.sv | 29 ++
 rtl/half_frame_tx_streamer.sv | 144 ++++++++++++++
 tb/tb_half_frame_tx_streamer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_pkg.sv
// Shared definitions for the downsized-frame transmit path.
package sift_pkg;

    // Byte sent ahead of every frame so the receiver can find frame boundaries.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        COLLECT,
        SYNC,
        WAIT,
        FETCH,
        LOAD,
        FIN
    } tx_state_t;

endpackage

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port block RAM, read-first, one cycle read latency.
module xilinx_single_port_ram_read_first #(
    parameter int unsigned RAM_WIDTH = 8,
    parameter int unsigned RAM_DEPTH = 1024
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         ena,
    input  logic                         regcea,
    output logic [RAM_WIDTH-1:0]         douta
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    // Write port and registered read; a write returns the previous contents.
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                mem[addra] <= dina;
            end
            if (regcea) begin
                douta <= mem[addra];
            end
        end
    end

endmodule

// File: rtl/half_frame_tx_streamer.sv
// Buffers one downsized frame, then streams it to uart_tx as a sync byte
// followed by every pixel in raster order.
module half_frame_tx_streamer
    import sift_pkg::*;
#(
    parameter int unsigned BIT_DEPTH  = 8,
    parameter int unsigned NEW_WIDTH  = 32,
    parameter int unsigned NEW_HEIGHT = 32,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [BIT_DEPTH-1:0]  data_in,
    input  logic [ADDR_WIDTH-1:0] data_addr_in,
    input  logic                  data_valid_in,
    output logic [7:0]            tx_data_out,
    output logic                  tx_start_out,
    input  logic                  tx_done_in,
    output logic                  frame_done_out,
    output logic                  busy_out,
    output logic                  error_out
);

    localparam int unsigned NPIX   = NEW_WIDTH * NEW_HEIGHT;
    localparam int unsigned CNT_W  = $clog2(NPIX + 1);
    localparam int unsigned RAM_AW = $clog2(NPIX);

    tx_state_t            state;
    tx_state_t            next_state;
    logic [CNT_W-1:0]     pix_cnt;
    logic [CNT_W-1:0]     rd_addr;
    logic [7:0]           byte_q;
    logic [BIT_DEPTH-1:0] ram_dout;
    logic [RAM_AW-1:0]    ram_addr;
    logic                 ram_en;
    logic                 addr_in_range;
    logic                 wr_accept;

    xilinx_single_port_ram_read_first #(
        .RAM_WIDTH (BIT_DEPTH),
        .RAM_DEPTH (NPIX)
    ) u_frame_buf (
        .addra  (ram_addr),
        .dina   (data_in),
        .clka   (clk_in),
        .wea    (wr_accept),
        .ena    (ram_en),
        .regcea (1'b1),
        .douta  (ram_dout)
    );

    // Collect-side qualification and buffer port sharing between collect and send.
    always_comb begin
        addr_in_range = 32'(data_addr_in) < NPIX;
        wr_accept     = data_valid_in && (state == COLLECT) && addr_in_range;
        ram_en        = wr_accept || (state == FETCH);
        ram_addr      = (state == COLLECT) ? data_addr_in[RAM_AW-1:0] : rd_addr[RAM_AW-1:0];
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and state-decoded outputs; outputs never see inputs directly.
    always_comb begin
        next_state     = state;
        tx_start_out   = 1'b0;
        frame_done_out = 1'b0;
        busy_out       = (state != COLLECT);
        tx_data_out    = byte_q;
        case (state)
            COLLECT: begin
                if (wr_accept && (pix_cnt == CNT_W'(NPIX - 1))) begin
                    next_state = SYNC;
                end
            end
            SYNC: begin
                tx_start_out = 1'b1;
                tx_data_out  = SYNC_BYTE;
                next_state   = WAIT;
            end
            WAIT: begin
                if (tx_done_in) begin
                    next_state = (rd_addr == CNT_W'(NPIX)) ? FIN : FETCH;
                end
            end
            FETCH: begin
                next_state = LOAD;
            end
            LOAD: begin
                // Show the fresh RAM word during the strobe; byte_q holds it afterwards.
                tx_start_out = 1'b1;
                tx_data_out  = ram_dout;
                next_state   = WAIT;
            end
            FIN: begin
                frame_done_out = 1'b1;
                next_state     = COLLECT;
            end
            default: begin
                next_state = COLLECT;
            end
        endcase
    end

    // Pixel/read counters, held output byte and sticky error flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pix_cnt   <= '0;
            rd_addr   <= '0;
            byte_q    <= '0;
            error_out <= 1'b0;
        end else begin
            if (wr_accept) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
            if (data_valid_in && ((state != COLLECT) || !addr_in_range)) begin
                error_out <= 1'b1;
            end
            case (state)
                SYNC: begin
                    byte_q <= SYNC_BYTE;
                end
                LOAD: begin
                    byte_q  <= ram_dout;
                    rd_addr <= rd_addr + 1'b1;
                end
                FIN: begin
                    pix_cnt <= '0;
                    rd_addr <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_half_frame_tx_streamer.sv
// Bench for half_frame_tx_streamer on a 4x4 frame with a behavioural uart_tx.
module tb_half_frame_tx_streamer;

    localparam int NP = 16;

    logic        clk_in;
    logic        rst_in;
    logic [7:0]  data_in;
    logic [10:0] data_addr_in;
    logic        data_valid_in;
    logic [7:0]  tx_data_out;
    logic        tx_start_out;
    logic        tx_done_in;
    logic        frame_done_out;
    logic        busy_out;
    logic        error_out;

    half_frame_tx_streamer #(
        .BIT_DEPTH  (8),
        .NEW_WIDTH  (4),
        .NEW_HEIGHT (4),
        .ADDR_WIDTH (11),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .data_in        (data_in),
        .data_addr_in   (data_addr_in),
        .data_valid_in  (data_valid_in),
        .tx_data_out    (tx_data_out),
        .tx_start_out   (tx_start_out),
        .tx_done_in     (tx_done_in),
        .frame_done_out (frame_done_out),
        .busy_out       (busy_out),
        .error_out      (error_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Behavioural uart_tx: done pulses 10 cycles after each start.
    initial begin
        tx_done_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (tx_start_out) begin
                repeat (10) @(posedge clk_in);
                #1 tx_done_in = 1'b1;
                @(posedge clk_in);
                #1 tx_done_in = 1'b0;
            end
        end
    end

    // Frame model: what was written, what must be sent, and when.
    logic [7:0] exp_mem [NP];
    logic [7:0] m_q [$];
    logic [7:0] tx_log [$];
    logic [7:0] m_last_byte = 8'h00;
    logic       m_busy = 1'b0;
    logic       m_err  = 1'b0;
    int         m_cnt = 0;
    int         m_byte_idx = 0;
    int         m_last_wr_cyc = 0;
    int         m_last_done = 0;
    int         m_fd_due = -1;
    int         n_frames = 0;
    int         cyc = 0;

    always @(negedge clk_in) begin
        logic [7:0] e;
        cyc++;
        chk("busy", busy_out, m_busy);
        chk("error", error_out, m_err);
        if (frame_done_out || cyc == m_fd_due)
            chk("frame_done", frame_done_out, cyc == m_fd_due);
        if (tx_start_out) begin
            if (m_q.size() == 0) begin
                chk("tx_start_unexpected", tx_start_out, 0);
            end else begin
                e = m_q.pop_front();
                chk("tx_byte", tx_data_out, e);
                if (m_byte_idx == 0) chk("sync_latency", cyc, m_last_wr_cyc + 1);
                else                 chk("done_to_start_gap", cyc - m_last_done, 2);
                m_byte_idx++;
                m_last_byte = e;
                tx_log.push_back(tx_data_out);
            end
        end else begin
            chk("tx_data_hold", tx_data_out, m_last_byte);
        end
        if (tx_done_in && m_busy) begin
            m_last_done = cyc;
            if (m_q.size() == 0 && m_byte_idx == NP + 1) m_fd_due = cyc + 1;
        end
        if (data_valid_in) begin
            if (m_busy || data_addr_in >= NP) begin
                m_err = 1'b1;
            end else begin
                exp_mem[data_addr_in] = data_in;
                m_cnt++;
                m_last_wr_cyc = cyc;
                if (m_cnt == NP) begin
                    m_busy = 1'b1;
                    m_cnt = 0;
                    m_byte_idx = 0;
                    m_q.delete();
                    m_q.push_back(8'hA5);
                    for (int i = 0; i < NP; i++) m_q.push_back(exp_mem[i]);
                end
            end
        end
        if (frame_done_out) begin
            m_busy = 1'b0;
            n_frames++;
        end
    end

    // Drive one strobe for one cycle; caller sits just after a rising edge.
    task automatic drive(input int a, input logic [7:0] v);
        data_valid_in = 1'b1;
        data_addr_in  = 11'(a);
        data_in       = v;
        @(posedge clk_in); #1;
        data_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_in); #1; end
    endtask

    task automatic wait_frame(input string name);
        int k = 0;
        do begin @(negedge clk_in); k++; end while (!frame_done_out && k < 1000);
        chk(name, frame_done_out, 1);
        @(posedge clk_in); #1;
    endtask

    task automatic wait_byte(input int n);
        int k = 0;
        while (m_byte_idx < n && k < 1000) begin @(negedge clk_in); k++; end
        chk("reach_byte", m_byte_idx, n);
        @(posedge clk_in); #1;
    endtask

    initial begin
        int fr;
        rst_in = 1'b0; data_in = '0; data_addr_in = '0; data_valid_in = 1'b0;
        repeat (3) @(posedge clk_in); #1;
        chk("rst_tx_data", tx_data_out, 0);
        chk("rst_tx_start", tx_start_out, 0);
        chk("rst_frame_done", frame_done_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_error", error_out, 0);
        rst_in = 1'b1;
        idle(2);

        // In-order frame, value = address.
        tx_log.delete(); fr = n_frames;
        for (int i = 0; i < NP; i++) drive(i, 8'(i));
        wait_frame("t1_done");
        chk("t1_bytes", tx_log.size(), 17);
        chk("t1_b0", tx_log[0], 8'hA5);
        chk("t1_b1", tx_log[1], 8'h00);
        chk("t1_b16", tx_log[16], 8'h0F);
        chk("t1_frames", n_frames - fr, 1);
        chk("t1_error", error_out, 0);
        idle(3);

        // Reverse addresses with idle gaps.
        tx_log.delete();
        for (int i = NP - 1; i >= 0; i--) begin drive(i, 8'hF0 | 8'(i)); idle(1); end
        wait_frame("t2_done");
        chk("t2_b1", tx_log[1], 8'hF0);
        chk("t2_b16", tx_log[16], 8'hFF);
        idle(2);

        // Back-to-back: second frame's first strobe right after frame_done.
        tx_log.delete();
        for (int i = 0; i < NP; i++) drive(i, 8'h10 + 8'(i));
        wait_frame("t6a_done");
        tx_log.delete();
        for (int i = 0; i < NP; i++) drive(i, 8'hCF - 8'(i));
        chk("t6_busy_after_16", busy_out, 1);
        wait_frame("t6b_done");
        chk("t6_b1", tx_log[1], 8'hCF);
        chk("t6_b16", tx_log[16], 8'hC0);
        idle(2);

        // Out-of-range address mid-collect.
        tx_log.delete();
        for (int i = 0; i < 5; i++) drive(i, 8'h30 + 8'(i));
        drive(16, 8'h55);
        for (int i = 5; i < 15; i++) drive(i, 8'h30 + 8'(i));
        chk("t3_busy_at_15", busy_out, 0);
        chk("t3_error", error_out, 1);
        drive(15, 8'h3F);
        chk("t3_busy_at_16", busy_out, 1);
        wait_frame("t3_done");
        begin
            int n55 = 0;
            foreach (tx_log[j]) if (tx_log[j] == 8'h55) n55++;
            chk("t3_no_55", n55, 0);
        end
        chk("t3_b16", tx_log[16], 8'h3F);
        idle(2);

        // Strobe while waiting on the UART.
        tx_log.delete();
        for (int i = 0; i < NP; i++) drive(i, 8'h40 + 8'(i));
        wait_byte(2);
        idle(2);
        drive(2, 8'hEE);
        chk("t4_busy", busy_out, 1);
        wait_frame("t4_done");
        chk("t4_b3", tx_log[3], 8'h42);
        chk("t4_error", error_out, 1);
        idle(2);

        // Reset during the 5th byte's wait, then a fresh frame.
        tx_log.delete();
        for (int i = 0; i < NP; i++) drive(i, 8'h60 + 8'(i));
        wait_byte(5);
        idle(2);
        #2 rst_in = 1'b0;
        #1;
        chk("t5_rst_tx_data", tx_data_out, 0);
        chk("t5_rst_tx_start", tx_start_out, 0);
        chk("t5_rst_busy", busy_out, 0);
        chk("t5_rst_error", error_out, 0);
        chk("t5_rst_frame_done", frame_done_out, 0);
        m_q.delete(); m_busy = 1'b0; m_err = 1'b0; m_cnt = 0;
        m_last_byte = 8'h00; m_byte_idx = 0; m_fd_due = -1;
        @(posedge clk_in); @(posedge clk_in); #1;
        rst_in = 1'b1;
        idle(30);
        tx_log.delete();
        for (int i = 0; i < NP; i++) drive(i, 8'h80 + 8'(i));
        wait_frame("t5_done");
        chk("t5_bytes", tx_log.size(), 17);
        chk("t5_b0", tx_log[0], 8'hA5);
        chk("t5_b5", tx_log[5], 8'h84);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
